// File: rtl/tdc_pkg.sv
// Shared definitions for the coarse TDC tile: FSM states, readback selects,
// ui_in bit positions and status byte layout.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2,
    ST_DONE    = 2'd3
  } tdc_state_e;

  typedef enum logic [1:0] {
    SEL_RES_LO = 2'd0,
    SEL_RES_HI = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_MEAS   = 2'd3
  } tdc_sel_e;

  localparam int UI_START  = 0;
  localparam int UI_STOP   = 1;
  localparam int UI_ARM    = 2;
  localparam int UI_CLEAR  = 3;
  localparam int UI_SEL_LO = 4;
  localparam int UI_SEL_HI = 5;

  localparam int STAT_STATE_HI = 7;
  localparam int STAT_STATE_LO = 6;
  localparam int STAT_OVF      = 5;
  localparam int STAT_VALID    = 4;

  function automatic logic [7:0] pack_status(input tdc_state_e st,
                                             input logic ovf,
                                             input logic vld);
    logic [7:0] b;
    b = 8'h00;
    b[STAT_STATE_HI:STAT_STATE_LO] = st;
    b[STAT_OVF]   = ovf;
    b[STAT_VALID] = vld;
    return b;
  endfunction

endpackage

// File: rtl/tdc_sync_edge.sv
// Multi-flop input synchronizer followed by a rising-edge detector that
// emits a single-cycle pulse per low-to-high transition.
module tdc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the shift chain a chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/tt_um_micro_tdc_coarse.sv
// Coarse time-to-digital converter tile: counts clk cycles between START and
// STOP rising edges and exposes result, status and measurement count on uo_out.
module tt_um_micro_tdc_coarse
  import tdc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic w_start, w_stop, w_arm, w_clear;

  tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_start (
    .clk(clk), .rst_n(rst_n), .i_d(ui_in[UI_START]), .o_rise(w_start));
  tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stop (
    .clk(clk), .rst_n(rst_n), .i_d(ui_in[UI_STOP]),  .o_rise(w_stop));
  tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_arm (
    .clk(clk), .rst_n(rst_n), .i_d(ui_in[UI_ARM]),   .o_rise(w_arm));
  tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clear (
    .clk(clk), .rst_n(rst_n), .i_d(ui_in[UI_CLEAR]), .o_rise(w_clear));

  logic w_unused_ui;
  assign w_unused_ui = &{1'b0, ui_in[7:6]};

  tdc_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_result, w_res_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [7:0]       r_meas;
  logic             w_done_entry;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_valid;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_valid   = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_res_nxt    = r_result;
    w_ovf_nxt    = r_ovf;
    w_done_entry = 1'b0;
    if (w_clear) begin
      w_state_nxt = ST_IDLE;
      w_res_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arm) w_state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (w_start && w_stop) begin
            w_res_nxt    = '0;
            w_state_nxt  = ST_DONE;
            w_done_entry = 1'b1;
          end else if (w_start) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          // The counter lags the elapsed edge count by one, hence the +1.
          if (w_stop) begin
            w_res_nxt    = w_cnt_inc;
            w_state_nxt  = ST_DONE;
            w_done_entry = 1'b1;
          end else if (w_cnt_inc == CNT_MAX) begin
            w_res_nxt    = CNT_MAX;
            w_ovf_nxt    = 1'b1;
            w_state_nxt  = ST_DONE;
            w_done_entry = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_DONE: begin
          if (w_arm) begin
            w_ovf_nxt   = 1'b0;
            w_state_nxt = ST_ARMED;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_meas   <= 8'h00;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_result <= w_res_nxt;
      r_ovf    <= w_ovf_nxt;
      if (w_done_entry) r_meas <= r_meas + 8'd1;
    end
  end

  logic [15:0] w_res16;
  logic [7:0]  w_rb;
  logic [7:0]  r_uo;

  assign w_res16 = 16'(r_result);

  always_comb begin
    w_rb = 8'h00;
    case (tdc_sel_e'(ui_in[UI_SEL_HI:UI_SEL_LO]))
      SEL_RES_LO: w_rb = w_res16[7:0];
      SEL_RES_HI: w_rb = w_res16[15:8];
      SEL_STATUS: w_rb = pack_status(r_state, r_ovf, w_valid);
      SEL_MEAS:   w_rb = r_meas;
      default:    w_rb = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_uo <= 8'h00;
    else        r_uo <= w_rb;
  end

  assign uo_out = r_uo;

endmodule

// File: tb/tb_tt_um_micro_tdc_coarse.sv
// Self-checking bench for the coarse TDC tile: randomized measurements
// compared against an interval-level reference model.
module tb_tt_um_micro_tdc_coarse;

  localparam int B_START = 0;
  localparam int B_STOP  = 1;
  localparam int B_ARM   = 2;
  localparam int B_CLEAR = 3;
  localparam int MAX_N   = 65535;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model in terms of the spec's externally visible quantities.
  int          m_state;
  logic        m_ovf;
  logic [15:0] m_result;
  int          m_meas;

  logic [7:0] rb    [4];
  logic [7:0] exp_b [4];

  always #5 clk = ~clk;

  tt_um_micro_tdc_coarse dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_all();
    for (int s = 0; s < 4; s++) begin
      ui_in[5:4] = 2'(s);
      tick(2);
      rb[s] = uo_out;
    end
    ui_in[5:4] = 2'b00;
  endtask

  task automatic model_bytes();
    logic [1:0] st;
    st = 2'(m_state);
    exp_b[0] = m_result[7:0];
    exp_b[1] = m_result[15:8];
    exp_b[2] = {st, m_ovf, (m_state == 3), 4'b0000};
    exp_b[3] = 8'(m_meas);
  endtask

  task automatic model_reset();
    m_state = 0; m_ovf = 1'b0; m_result = 16'h0000; m_meas = 0;
  endtask

  task automatic model_done(input int n);
    if (n >= MAX_N) begin
      m_result = 16'hFFFF; m_ovf = 1'b1;
    end else begin
      m_result = 16'(n); m_ovf = 1'b0;
    end
    m_state = 3;
    m_meas  = (m_meas + 1) % 256;
  endtask

  task automatic pulse_bit(input int b);
    ui_in[b] = 1'b1;
    tick(1);
    ui_in[b] = 1'b0;
    tick(1);
  endtask

  task automatic do_arm();
    pulse_bit(B_ARM);
    tick(3);
    m_state = 1; m_ovf = 1'b0;
  endtask

  // START sampled at edge k, STOP sampled at edge k+n (n=0: same edge).
  task automatic measure(input int n);
    ui_in[B_START] = 1'b1;
    if (n > 0) tick(n);
    ui_in[B_STOP] = 1'b1;
    tick(6);
    ui_in[B_STOP]  = 1'b0;
    ui_in[B_START] = 1'b0;
    tick(1);
    model_done(n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ui_in = 8'h00;
    tick(3);
    n_checks++;
    if (uo_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_uo got 0x%02h expected 0x00", uo_out);
    end
    rst_n = 1'b1;
    tick(2);
    model_reset(); model_bytes(); read_all();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL reset_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_basic();
    tick(10);
    do_arm();
    measure(100);
    model_bytes(); read_all();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL basic_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
      end
    end
    n_checks++;
    if (rb[2] !== 8'hD0 || rb[0] !== 8'h64) begin
      n_fail++; $display("FAIL basic_literal got status 0x%02h lo 0x%02h expected 0xd0 0x64", rb[2], rb[0]);
    end
  endtask

  task automatic test_simultaneous();
    do_arm();
    measure(0);
    model_bytes(); read_all();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL simul_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_stop_alone();
    do_arm();
    ui_in[B_STOP] = 1'b1;
    tick(6);
    ui_in[B_STOP] = 1'b0;
    tick(2);
    model_bytes(); read_all();
    n_checks++;
    if (rb[2] !== exp_b[2]) begin
      n_fail++; $display("FAIL stop_alone_status got 0x%02h expected 0x%02h", rb[2], exp_b[2]);
    end
    measure(7);
    model_bytes(); read_all();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL stop_alone_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int n;
      do_arm();
      tick($urandom_range(0, 5));
      n = $urandom_range(1, 700);
      if (it == 0) n = 1;
      if (it == 1) n = 256;
      measure(n);
      model_bytes(); read_all();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rb[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL random_n%0d_sel%0d got 0x%02h expected 0x%02h", n, i, rb[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_arm();
    ui_in[B_START] = 1'b1;
    tick(MAX_N + 20);
    model_done(MAX_N);
    model_bytes(); read_all();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL ovf_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
      end
    end
    ui_in[B_STOP] = 1'b1;
    tick(6);
    read_all();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL ovf_late_stop_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
      end
    end
    ui_in[B_STOP] = 1'b0; ui_in[B_START] = 1'b0;
    tick(2);
  endtask

  task automatic test_clear();
    do_arm();
    ui_in[B_START] = 1'b1;
    tick(50);
    pulse_bit(B_CLEAR);
    tick(3);
    m_state = 0; m_ovf = 1'b0; m_result = 16'h0000;
    model_bytes(); read_all();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL clear_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
      end
    end
    tick(12);
    ui_in[B_STOP] = 1'b1;
    tick(6);
    read_all();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL clear_late_stop_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
      end
    end
    ui_in[B_STOP] = 1'b0; ui_in[B_START] = 1'b0;
    tick(2);
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    model_reset();
    for (int k = 0; k < 256; k++) begin
      do_arm();
      measure(3);
      if (k == 254) begin
        model_bytes(); read_all();
        for (int i = 0; i < 4; i++) begin
          n_checks++;
          if (rb[i] !== exp_b[i]) begin
            n_fail++; $display("FAIL b2b_255_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
          end
        end
      end
    end
    model_bytes(); read_all();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL b2b_wrap_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
      end
    end
    n_checks++;
    if (rb[3] !== 8'h00) begin
      n_fail++; $display("FAIL b2b_wrap_literal got 0x%02h expected 0x00", rb[3]);
    end
  endtask

  task automatic test_reset_mid();
    do_arm();
    ui_in[B_START] = 1'b1;
    ui_in[5:4] = 2'b11;
    tick(20);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (uo_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_async got 0x%02h expected 0x00", uo_out);
    end
    ui_in[B_START] = 1'b0;
    model_reset(); model_bytes(); read_all();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL reset_mid_held_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
      end
    end
    rst_n = 1'b1;
    tick(4);
    read_all();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL reset_mid_after_sel%0d got 0x%02h expected 0x%02h", i, rb[i], exp_b[i]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_simultaneous();
    test_stop_alone();
    test_random();
    test_overflow();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
